// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache for the MEM stage.
// Misses stall the CPU while the victim is written back and the line is refilled.
//
// state     | meaning
// IDLE      | lookup active; hits complete, misses latch index/tag/victim
// WRITEBACK | dirty victim line being written to memory
// REFILL    | missing line being read from memory into the victim way
module dcache_2way #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]             valid0, valid1, dirty0, dirty1, lru;
  logic [SETS-1:0][TAG_W-1:0]  tag0, tag1;
  logic [WORDS-1:0][31:0]      line0 [SETS];
  logic [WORDS-1:0][31:0]      line1 [SETS];

  logic [IDX_W-1:0]  idx, miss_idx;
  logic [TAG_W-1:0]  tag, miss_tag, vict_tag;
  logic [WSEL_W-1:0] wsel;
  logic              hit0, hit1, hit, req, idle;
  logic              lookup_hit, lookup_miss;
  logic              vict, vict_dirty, vict_q;
  logic [LINE_W-1:0] vict_line;
  logic [1:0]        unused_addr;

  assign unused_addr = p1_addr_i[1:0];

  assign idx  = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag  = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign wsel = p1_addr_i[OFF_W-1:2];

  assign idle = (state == IDLE);
  assign req  = p1_MemRead_i | p1_MemWrite_i;
  assign hit0 = valid0[idx] & (tag0[idx] == tag);
  assign hit1 = valid1[idx] & (tag1[idx] == tag);
  assign hit  = hit0 | hit1;

  assign lookup_hit  = idle & req & hit;
  assign lookup_miss = idle & req & ~hit;

  // Fill invalid ways first, in way order, before evicting the LRU way.
  assign vict       = ~valid0[idx] ? 1'b0 : (~valid1[idx] ? 1'b1 : lru[idx]);
  assign vict_dirty = vict ? (valid1[idx] & dirty1[idx]) : (valid0[idx] & dirty0[idx]);

  assign vict_tag  = vict_q ? tag1[miss_idx] : tag0[miss_idx];
  assign vict_line = vict_q ? line1[miss_idx] : line0[miss_idx];

  assign p1_stall_o = ~idle | (req & ~hit);
  assign p1_data_o  = (idle & p1_MemRead_i & hit) ?
                      (hit0 ? line0[idx][wsel] : line1[idx][wsel]) : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (lookup_miss) state_nxt = vict_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack_i)   state_nxt = REFILL;
      REFILL:    if (mem_ack_i)   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {vict_tag, miss_idx, {OFF_W{1'b0}}};
        mem_data_o   = vict_line;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid0     <= '0;
      valid1     <= '0;
      dirty0     <= '0;
      dirty1     <= '0;
      lru        <= '0;
      tag0       <= '0;
      tag1       <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      vict_q     <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt_o <= hit_cnt_o + CNT_W'(1);
        lru[idx]  <= hit0;
        if (p1_MemWrite_i) begin
          if (hit0) dirty0[idx] <= 1'b1;
          else      dirty1[idx] <= 1'b1;
        end
      end
      if (lookup_miss) begin
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
        miss_idx   <= idx;
        miss_tag   <= tag;
        vict_q     <= vict;
      end
      if (state == REFILL && mem_ack_i) begin
        if (vict_q) begin
          valid1[miss_idx] <= 1'b1;
          dirty1[miss_idx] <= 1'b0;
          tag1[miss_idx]   <= miss_tag;
        end else begin
          valid0[miss_idx] <= 1'b1;
          dirty0[miss_idx] <= 1'b0;
          tag0[miss_idx]   <= miss_tag;
        end
      end
    end
  end

  // Line storage is not reset; the valid bits make stale contents invisible.
  always_ff @(posedge clk_i) begin
    if (lookup_hit && p1_MemWrite_i) begin
      if (hit0) line0[idx][wsel] <= p1_data_i;
      else      line1[idx][wsel] <= p1_data_i;
    end
    if (state == REFILL && mem_ack_i) begin
      if (vict_q) line1[miss_idx] <= mem_data_i;
      else        line0[miss_idx] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: hits, clean and dirty misses, LRU victim choice,
// stray acks while idle and reset in the middle of a refill.
module tb_dcache_2way;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  logic [255:0] l0, l1, l2, l3;

  always #5 clk_i = ~clk_i;

  dcache_2way dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .p1_data_i    (p1_data_i),
    .p1_addr_i    (p1_addr_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w1);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    l[63:32] = w1;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = a;
    p1_data_i     = d;
  endtask

  task automatic do_hit(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string tag);
    drive(rd, wr, a, d);
    #1;
    check_eq({tag, "_stall"}, p1_stall_o, 1'b0);
    if (rd && !wr) check_eq({tag, "_data"}, p1_data_o, exp_rd);
    tick();
    exp_hit++;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq({tag, "_hits"}, hit_cnt_o, exp_hit);
  endtask

  task automatic do_miss(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic wb, input logic [31:0] wb_addr, input logic [31:0] wb_w1,
                         input logic [255:0] fill, input logic [31:0] exp_rd, input string tag);
    drive(rd, wr, a, d);
    #1;
    check_eq({tag, "_stall0"}, p1_stall_o, 1'b1);
    tick();
    exp_miss++;
    check_eq({tag, "_misses"}, miss_cnt_o, exp_miss);
    if (wb) begin
      check_eq({tag, "_wb_en"}, mem_enable_o, 1'b1);
      check_eq({tag, "_wb_we"}, mem_write_o, 1'b1);
      check_eq({tag, "_wb_addr"}, mem_addr_o, wb_addr);
      check_eq({tag, "_wb_w1"}, mem_data_o[63:32], wb_w1);
      tick();
      mem_data_i = '1;
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      mem_data_i = '0;
    end
    check_eq({tag, "_rf_en"}, mem_enable_o, 1'b1);
    check_eq({tag, "_rf_we"}, mem_write_o, 1'b0);
    check_eq({tag, "_rf_addr"}, mem_addr_o, a & ~32'h1F);
    check_eq({tag, "_stall1"}, p1_stall_o, 1'b1);
    tick();
    mem_data_i = fill;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    check_eq({tag, "_stall_done"}, p1_stall_o, 1'b0);
    check_eq({tag, "_idle_en"}, mem_enable_o, 1'b0);
    if (rd && !wr) check_eq({tag, "_data"}, p1_data_o, exp_rd);
    tick();
    exp_hit++;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq({tag, "_hits"}, hit_cnt_o, exp_hit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    l0 = mk_line(32'h0A00_0000, 32'h0A0A_0A0A);
    l1 = mk_line(32'h1000_0000, 32'hDEAD_BEEF);
    l2 = mk_line(32'h2000_0000, 32'h2222_2222);
    l3 = mk_line(32'h3000_0000, 32'h3333_3333);
    rst_i = 1'b0;
    mem_data_i = '0;
    mem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    check_eq("rst_en", mem_enable_o, 1'b0);
    check_eq("rst_we", mem_write_o, 1'b0);
    check_eq("rst_addr", mem_addr_o, 32'h0);
    check_eq("rst_mdata", mem_data_o, 256'h0);
    check_eq("rst_pdata", p1_data_o, 32'h0);
    check_eq("rst_stall_noreq", p1_stall_o, 1'b0);
    check_eq("rst_hits", hit_cnt_o, 32'h0);
    check_eq("rst_misses", miss_cnt_o, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    #1;
    check_eq("rst_stall_req", p1_stall_o, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Clean miss into way0, then hits on the refilled line.
    do_miss(1'b1, 1'b0, 32'h0000_0404, 32'h0, 1'b0, 32'h0, 32'h0, l1, 32'hDEAD_BEEF, "rd404");
    do_hit(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0, "wr404");
    do_hit(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h1234_5678, "rd404b");
    do_hit(1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'h1000_0002, "rd408");
    do_hit(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h1000_0000, "rd400");

    // Same set: way1 fills clean, then the dirty LRU way0 is written back.
    do_miss(1'b1, 1'b0, 32'h0000_0804, 32'h0, 1'b0, 32'h0, 32'h0, l2, 32'h2222_2222, "rd804");
    do_miss(1'b1, 1'b0, 32'h0000_0C04, 32'h0, 1'b1, 32'h0000_0400, 32'h1234_5678,
            l3, 32'h3333_3333, "rdC04");
    do_hit(1'b1, 1'b0, 32'h0000_0804, 32'h0, 32'h2222_2222, "rd804b");

    // Read and write together on a hit act as a store and dirty way1.
    do_hit(1'b1, 1'b1, 32'h0000_0804, 32'hCAFE_F00D, 32'h0, "rw804");
    do_hit(1'b1, 1'b0, 32'h0000_0804, 32'h0, 32'hCAFE_F00D, "rd804c");
    do_miss(1'b1, 1'b0, 32'h0000_0404, 32'h0, 1'b0, 32'h0, 32'h0, l1, 32'hDEAD_BEEF, "rd404c");
    do_miss(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0800, 32'hCAFE_F00D,
            l0, 32'h0A0A_0A0A, "rd004");

    // Stray ack while idle must not disturb state or contents.
    mem_data_i = '1;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    check_eq("ack_idle_en", mem_enable_o, 1'b0);
    check_eq("ack_idle_stall", p1_stall_o, 1'b0);
    check_eq("ack_idle_misses", miss_cnt_o, exp_miss);
    do_hit(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0A0A_0A0A, "rd004b");
    do_hit(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, "rd404d");

    // Reset asserted in REFILL aborts the transfer and clears everything.
    drive(1'b1, 1'b0, 32'h0000_0804, 32'h0);
    tick();
    check_eq("abort_pre_en", mem_enable_o, 1'b1);
    check_eq("abort_pre_we", mem_write_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check_eq("abort_en", mem_enable_o, 1'b0);
    check_eq("abort_hits", hit_cnt_o, 32'h0);
    check_eq("abort_misses", miss_cnt_o, 32'h0);
    check_eq("abort_stall", p1_stall_o, 1'b1);
    #2;
    rst_i = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    do_miss(1'b1, 1'b0, 32'h0000_0804, 32'h0, 1'b0, 32'h0, 32'h0, l2, 32'h2222_2222, "rst804");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU data port and the 256-bit-class data memory. Successor to the one-way data cache: adds configurable line/set geometry, two ways with per-set LRU replacement, on-chip valid/dirty/tag state cleared by reset, a latched miss address, and hit/miss performance counters. Sits in the MEM stage; stalls the pipeline on a miss while it performs writeback and refill over a single-request memory handshake.

## Interface
- ADDR_W, 32, byte-address width
- LINE_W, 256, line width in bits (power of two, ≥64); OFF_W = log2(LINE_W/8)
- SETS, 32, number of sets (power of two); IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W
- CNT_W, 32, performance counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_data_i  in  LINE_W  refill line, valid when mem_ack_i=1
- mem_ack_i  in  1  single-cycle completion pulse for current memory request
- mem_data_o  out  LINE_W  victim line during writeback, else 0
- mem_addr_o  out  ADDR_W  line-aligned request address (low OFF_W bits 0), 0 when idle
- mem_enable_o  out  1  memory request active
- mem_write_o  out  1  1 = writeback, 0 = refill read
- p1_data_i  in  32  store data
- p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request (wins if both asserted)
- p1_data_o  out  32  load data, 0 when no hit
- p1_stall_o  out  1  request not completing this cycle
- hit_cnt_o  out  CNT_W  hit count, wraps
- miss_cnt_o  out  CNT_W  miss count, wraps

## Operation
- Address split: offset [OFF_W-1:0], word select [OFF_W-1:2], index [OFF_W+IDX_W-1:OFF_W], tag [ADDR_W-1:OFF_W+IDX_W].
- Per set, per way: valid, dirty, tag, line; per set: one LRU bit naming the least-recently-used way.
- Lookup (combinational, IDLE only): hit_w = valid_w & tag_w==tag; both ways hitting is impossible by construction. req = read|write; p1_stall_o = req & ~hit, forced 1 in any non-IDLE state.
- Read hit: p1_data_o = selected 32-bit word of hitting way. Write hit: on the clock edge write word, set dirty. Any hit sets LRU to the other way.
- Miss (IDLE, req & ~hit): latch index/tag; victim = way0 if invalid, else way1 if invalid, else LRU way. miss_cnt_o += 1. Next state WRITEBACK if victim valid & dirty, else REFILL.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, latched index, 0}, mem_data_o=victim line. On mem_ack_i → REFILL.
- REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={latched tag, latched index, 0}. On mem_ack_i, at that edge: victim line ← mem_data_i, tag ← latched tag, valid=1, dirty=0; → IDLE. Access then re-looks-up with current inputs and completes as a hit (write-miss = refill + write hit).
- hit_cnt_o += 1 every IDLE cycle with req & hit (includes post-refill completion).
- States: IDLE, WRITEBACK, REFILL. mem_enable_o/mem_write_o/mem_addr_o/mem_data_o decoded from state; all 0 in IDLE.

## Timing
- Reset (async, rst_i=0): state IDLE, all valid/dirty/LRU=0, counters 0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0, p1_stall_o=req (all lines invalid). Reset during WRITEBACK/REFILL aborts immediately; dirty data lost.
- Hit: zero-latency read, store committed at the same edge, stall 0.
- Clean miss: stall from cycle 0; REFILL from cycle 1; with ack in cycle N, stall deasserts cycle N+1.
- Dirty miss: additional WRITEBACK cycles ending in its ack; ack in WRITEBACK never writes the cache.
- mem_ack_i outside WRITEBACK/REFILL is ignored. CPU inputs may change while stalled; in-flight transfer uses latched address.

## Test plan
- Reset, read 0x0000_0404 → stall=1, next cycle mem_enable_o=1, mem_write_o=0, mem_addr_o=0x0000_0400; ack with word1=0xDEADBEEF → next cycle stall=0, p1_data_o=0xDEADBEEF, miss_cnt_o=1, hit_cnt_o=1.
- Write 0x0000_0404 data 0x12345678 → no stall; following read returns 0x12345678; other words unchanged.
- Read 0x0000_0804 (same set) → refill into way1, no writeback. Read 0x0000_0C04 → writeback, mem_addr_o=0x0000_0400, mem_data_o word1=0x12345678, then refill at 0x0000_0C00; 0x0000_0804 still hits afterwards.
- Read and write both asserted on a hit → treated as store, dirty set, later eviction issues writeback.
- Deassert rst_i during REFILL → mem_enable_o=0 same cycle, counters 0; read 0x0000_0804 misses again.
- Ack pulse while IDLE → no state change, no cache write.
